network_batch_ctrl: RTL and testbench
=====================================

Name: network_batch_ctrl

Overview:
- Synthesizable run sequencer for one or more Network instances.
- Launches NUM_CH networks in parallel and detects the rising edge of each done.
- Repeats for RUNS iterations, captures each channel's out word and guards every run with a cycle timeout.
- Sits between the top-level control and the Network array; replaces ad-hoc start/done counting.

Parameters:
- NUM_CH, 1, number of parallel Network channels.
- DATA_W, 32, width of each channel's out word.
- RUNS, 3, runs per batch (>=1).
- TIMEOUT_W, 16, width of the per-run timeout counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  single-cycle request to start a batch; ignored unless idle.
- abort  input  1  synchronous abort; forces return to IDLE.
- timeout_lim  input  TIMEOUT_W  maximum cycles per run; 0 disables the timeout.
- net_start  output  NUM_CH  per-channel start to Network.
- net_done  input  NUM_CH  per-channel done from Network (level; rising edge is the event).
- net_out  input  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- busy  output  1  high from accept of go until return to IDLE.
- batch_done  output  1  one-cycle pulse on successful batch completion.
- timeout_err  output  1  sticky error flag; cleared by the next accepted go or by reset.
- run_count  output  $clog2(RUNS+1)  number of completed runs in the current batch.
- result  output  NUM_CH*DATA_W  captured output words.
- result_valid  output  1  high once result holds a complete batch; cleared on the next accepted go.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - net_start, busy, batch_done, timeout_err, result_valid = 0.
  - run_count = 0, result = 0.
  - done-edge registers = 0.
- Edge detect: done_q registers net_done every cycle. A done event on channel c is net_done[c] & ~done_q[c].
- Per-channel pending mask pend[NUM_CH-1:0] tracks channels still running.
- States:
  - IDLE:
    - go=1 -> LAUNCH.
    - Clear run_count, timeout_err and result_valid.
    - busy goes high in the next cycle.
  - LAUNCH (1 cycle):
    - pend = all ones, timeout counter = 0.
    - net_start = all ones, registered; visible the cycle after LAUNCH is entered.
    - -> WAIT.
  - WAIT:
    - net_start[c] = pend[c].
    - On a done event for channel c: latch net_out slice c into result slice c in the same cycle, then clear pend[c].
    - Timeout counter increments each cycle.
    - pend == 0 -> GAP.
    - If timeout_lim != 0 and counter == timeout_lim-1 while pend != 0 -> ERROR.
  - GAP (1 cycle):
    - net_start = 0, giving Network a low start between runs.
    - run_count increments.
    - If run_count+1 == RUNS -> FINISH; else -> LAUNCH.
  - FINISH (1 cycle): batch_done=1, result_valid=1 -> IDLE.
  - ERROR (1 cycle):
    - timeout_err=1, net_start=0.
    - result holds partial data and result_valid stays 0.
    - -> IDLE.
- Per-run latency: 1 (LAUNCH) + done latency + 1 (GAP). batch_done asserts 1 cycle after the final GAP.
- Boundary conditions:
  - Simultaneous done events on several channels: all are captured in the same cycle.
  - Done event when pend[c]=0: ignored; result is unchanged.
  - net_done already high at LAUNCH: no event is seen until it falls and rises again.
  - abort in any state: next state IDLE, net_start=0, no batch_done. abort has priority over go, done events and timeout.
  - go while busy: ignored.
  - Mid-operation reset: immediate return to the reset values.
  - run_count saturates at RUNS and never wraps.

Optional Feature:
- Macro: NETWORK_BATCH_ACCUM_EN.
- Defined:
  - Each done event adds net_out slice c to result slice c, modulo 2^DATA_W.
  - result is cleared to 0 on an accepted go, so the final result is the sum over RUNS runs.
- Undefined: result slice c holds the value captured at the last run only.

Test Plan:
- NUM_CH=1, RUNS=3, net_done rises 5 cycles after each start with net_out=32'h0000_0010 -> three GAPs, batch_done pulses once, run_count=3, result=32'h10; with ACCUM_EN, result=32'h30.
- NUM_CH=2; channel 0 done after 3 cycles (out=0xA), channel 1 after 7 cycles (out=0xB) -> net_start[0] drops first, the run ends only after channel 1, result={0xB,0xA}.
- timeout_lim=4, channel never completes -> ERROR after 4 WAIT cycles, timeout_err=1, result_valid=0, batch_done never pulses, net_start=0.
- abort asserted in WAIT of run 2 -> IDLE next cycle, busy=0, run_count=1, no batch_done; a following go clears run_count and runs a full batch.
- go repeated while busy, plus a spurious done when pend=0 -> no restart, result unchanged; reset pulsed mid-WAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/network_batch_ctrl.sv
// network_batch_ctrl: run sequencer for NUM_CH parallel Network channels.
// Launches every channel, waits for the rising edge of each done, captures
// each channel's out word, and repeats for RUNS runs. Each run is guarded by
// a cycle timeout.
// Optional macro NETWORK_BATCH_ACCUM_EN: accumulate out words over the batch
// instead of keeping the last run's value.
module network_batch_ctrl #(
    parameter int NUM_CH    = 1,
    parameter int DATA_W    = 32,
    parameter int RUNS      = 3,
    parameter int TIMEOUT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic                         abort,
    input  logic [TIMEOUT_W-1:0]         timeout_lim,
    output logic [NUM_CH-1:0]            net_start,
    input  logic [NUM_CH-1:0]            net_done,
    input  logic [NUM_CH*DATA_W-1:0]     net_out,
    output logic                         busy,
    output logic                         batch_done,
    output logic                         timeout_err,
    output logic [$clog2(RUNS+1)-1:0]    run_count,
    output logic [NUM_CH*DATA_W-1:0]     result,
    output logic                         result_valid
);

    localparam int CNT_W = $clog2(RUNS + 1);
    localparam logic [CNT_W-1:0] RUNS_C = CNT_W'(RUNS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [NUM_CH-1:0]         done_q;
    logic [NUM_CH-1:0]         pend_q, pend_d;
    logic [TIMEOUT_W-1:0]      tcnt_q, tcnt_d;
    logic [NUM_CH-1:0]         net_start_q, net_start_d;
    logic                      busy_q, busy_d;
    logic                      batch_done_q, batch_done_d;
    logic                      timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]          run_count_q, run_count_d;
    logic [NUM_CH*DATA_W-1:0]  result_q, result_d;
    logic                      result_valid_q, result_valid_d;
    logic [NUM_CH-1:0]         ev_s;

    // Next-state and output computation; abort overrides everything else.
    always_comb begin
        ev_s           = net_done & ~done_q & pend_q;
        state_d        = state_q;
        pend_d         = pend_q;
        tcnt_d         = tcnt_q;
        batch_done_d   = 1'b0;
        timeout_err_d  = timeout_err_q;
        run_count_d    = run_count_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_d        = S_LAUNCH;
                        run_count_d    = '0;
                        timeout_err_d  = 1'b0;
                        result_valid_d = 1'b0;
`ifdef NETWORK_BATCH_ACCUM_EN
                        result_d       = '0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    pend_d  = '1;
                    tcnt_d  = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // Capture only channels whose done rose while still pending.
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ev_s[c]) begin
`ifdef NETWORK_BATCH_ACCUM_EN
                            result_d[c*DATA_W +: DATA_W] = result_q[c*DATA_W +: DATA_W]
                                                         + net_out[c*DATA_W +: DATA_W];
`else
                            result_d[c*DATA_W +: DATA_W] = net_out[c*DATA_W +: DATA_W];
`endif
                        end else begin
                            result_d[c*DATA_W +: DATA_W] = result_q[c*DATA_W +: DATA_W];
                        end
                    end
                    pend_d = pend_q & ~ev_s;
                    tcnt_d = tcnt_q + TIMEOUT_W'(1);
                    // Completion in the last allowed cycle wins over the timeout.
                    if (pend_d == '0) begin
                        state_d = S_GAP;
                    end else if ((timeout_lim != '0) &&
                                 (tcnt_q == timeout_lim - TIMEOUT_W'(1))) begin
                        state_d       = S_ERROR;
                        timeout_err_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_GAP: begin
                    if (run_count_q < RUNS_C) begin
                        run_count_d = run_count_q + CNT_W'(1);
                    end else begin
                        run_count_d = run_count_q;
                    end
                    // Flags are raised here so they are visible during FINISH.
                    if (run_count_q >= RUNS_C - CNT_W'(1)) begin
                        state_d        = S_FINISH;
                        batch_done_d   = 1'b1;
                        result_valid_d = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                S_ERROR:  state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
        if (state_d == S_WAIT) begin
            net_start_d = pend_d;
        end else begin
            net_start_d = '0;
        end
    end

    // State, edge-detect and registered output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            done_q         <= '0;
            pend_q         <= '0;
            tcnt_q         <= '0;
            net_start_q    <= '0;
            busy_q         <= 1'b0;
            batch_done_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
            run_count_q    <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            done_q         <= net_done;
            pend_q         <= pend_d;
            tcnt_q         <= tcnt_d;
            net_start_q    <= net_start_d;
            busy_q         <= busy_d;
            batch_done_q   <= batch_done_d;
            timeout_err_q  <= timeout_err_d;
            run_count_q    <= run_count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign net_start    = net_start_q;
    assign busy         = busy_q;
    assign batch_done   = batch_done_q;
    assign timeout_err  = timeout_err_q;
    assign run_count    = run_count_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_network_batch_ctrl.sv
// Bench for network_batch_ctrl: table of batch scenarios plus random ones,
// a Network responder model, and hand sequences for abort/reset corners.
module tb_network_batch_ctrl;
    localparam int NUM_CH = 2, DATA_W = 32, RUNS = 3, TIMEOUT_W = 16;
    localparam int CW = $clog2(RUNS + 1);

    logic clk = 1'b0, reset = 1'b0, go = 1'b0, abort = 1'b0;
    logic [TIMEOUT_W-1:0] timeout_lim = '0;
    logic [NUM_CH-1:0] net_start, net_done;
    logic [NUM_CH*DATA_W-1:0] net_out, result;
    logic busy, batch_done, timeout_err, result_valid;
    logic [CW-1:0] run_count;
    int total = 0, bad = 0;

    typedef struct {
        int d0; int d1;
        logic [31:0] b0; logic [31:0] s0; logic [31:0] b1; logic [31:0] s1;
        logic [15:0] tlim; bit glitch; bit go_busy;
        bit err; int cycles; logic [63:0] res_last; logic [63:0] res_sum; logic [1:0] keep;
    } vec_t;

    // Network responder state
    bit emu_en = 1'b1;
    int dly[NUM_CH], cnt[NUM_CH], gl[NUM_CH], ridx[NUM_CH];
    bit st[NUM_CH], glit[NUM_CH];
    logic [31:0] ebase[NUM_CH], estep[NUM_CH];
    logic [63:0] prev = '0;

    network_batch_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .RUNS(RUNS), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort), .timeout_lim(timeout_lim),
        .net_start(net_start), .net_done(net_done), .net_out(net_out), .busy(busy),
        .batch_done(batch_done), .timeout_err(timeout_err), .run_count(run_count),
        .result(result), .result_valid(result_valid));

    always #5 clk = ~clk;

    // Network model: done rises dly cycles after start is seen, drops when start drops.
    initial begin
        net_done = '0;
        net_out  = '0;
        forever begin
            @(negedge clk);
            if (emu_en) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (net_start[c] && !st[c]) begin
                        st[c] = 1'b1; cnt[c] = 0; gl[c] = 0;
                    end else if (net_start[c]) begin
                        cnt[c]++;
                        if (cnt[c] == dly[c]) begin
                            net_done[c] = 1'b1;
                            net_out[c*DATA_W +: DATA_W] = ebase[c] + estep[c] * 32'(ridx[c]);
                        end
                    end else if (st[c]) begin
                        st[c] = 1'b0; net_done[c] = 1'b0; ridx[c]++;
                        gl[c] = glit[c] ? 1 : 0;
                    end else if (gl[c] == 1) begin
                        net_done[c] = 1'b1; net_out[c*DATA_W +: DATA_W] = 32'hDEAD_BEEF; gl[c] = 2;
                    end else if (gl[c] == 2) begin
                        net_done[c] = 1'b0; gl[c] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s actual=%h expected=%h", tag, nm, act, exp);
        end
    endtask

    // Reference: derive expected batch outcome from run rules with plain arithmetic.
    function automatic vec_t mk(int d0, int d1, logic [31:0] b0, logic [31:0] s0, logic [31:0] b1,
                                logic [31:0] s1, logic [15:0] tl, bit g, bit gb);
        vec_t v; int m; int dd[2]; logic [31:0] bb[2], ss[2], acc;
        v.d0 = d0; v.d1 = d1; v.b0 = b0; v.s0 = s0; v.b1 = b1; v.s1 = s1;
        v.tlim = tl; v.glitch = g; v.go_busy = gb;
        dd[0] = d0; dd[1] = d1; bb[0] = b0; bb[1] = b1; ss[0] = s0; ss[1] = s1;
        m = (d0 > d1) ? d0 : d1;
        v.err = (tl != 16'd0) && (int'(tl) < m + 1);
        v.cycles = v.err ? int'(tl) + 2 : RUNS * (m + 3) + 1;
        v.keep = '0; v.res_last = '0; v.res_sum = '0;
        for (int c = 0; c < 2; c++) begin
            if (v.err) begin
                v.keep[c] = (1 + dd[c] > int'(tl));
                if (!v.keep[c]) begin
                    v.res_last[c*32 +: 32] = bb[c];
                    v.res_sum[c*32 +: 32]  = bb[c];
                end
            end else begin
                acc = '0;
                for (int r = 0; r < RUNS; r++) acc = acc + bb[c] + ss[c] * 32'(r);
                v.res_last[c*32 +: 32] = bb[c] + ss[c] * 32'(RUNS - 1);
                v.res_sum[c*32 +: 32]  = acc;
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] resolve(vec_t v);
        logic [63:0] r;
`ifdef NETWORK_BATCH_ACCUM_EN
        r = v.res_sum;
        for (int c = 0; c < 2; c++) if (v.keep[c]) r[c*32 +: 32] = 32'h0;
`else
        r = v.res_last;
        for (int c = 0; c < 2; c++) if (v.keep[c]) r[c*32 +: 32] = prev[c*32 +: 32];
`endif
        return r;
    endfunction

    task automatic set_emu(vec_t v);
        dly[0] = v.d0; dly[1] = v.d1; ebase[0] = v.b0; ebase[1] = v.b1;
        estep[0] = v.s0; estep[1] = v.s1; glit[0] = v.glitch; glit[1] = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin ridx[c] = 0; gl[c] = 0; st[c] = 1'b0; end
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(posedge clk); #1; go = 1'b0;
    endtask

    task automatic run_scenario(input vec_t v, input string tag);
        int n, any, one, blo, m, df;
        logic [63:0] er;
        set_emu(v);
        timeout_lim = v.tlim;
        er = resolve(v);
        pulse_go();
        chk(tag, "busy_on", 64'(busy), 64'd1);
        chk(tag, "rc_clear", 64'(run_count), 64'd0);
        chk(tag, "terr_clear", 64'(timeout_err), 64'd0);
        chk(tag, "rv_clear", 64'(result_valid), 64'd0);
`ifdef NETWORK_BATCH_ACCUM_EN
        chk(tag, "res_clear", result, 64'd0);
`endif
        n = 1; any = 0; one = 0; blo = 0;
        forever begin
            if (net_start != 2'b00) any++;
            if (net_start == 2'b01 || net_start == 2'b10) one++;
            if (!busy) blo++;
            if (batch_done || timeout_err || n >= 400) break;
            go = (v.go_busy && n == 3);
            @(posedge clk); #1; n++;
        end
        go = 1'b0;
        m = (v.d0 > v.d1) ? v.d0 : v.d1;
        df = (v.d0 > v.d1) ? v.d0 - v.d1 : v.d1 - v.d0;
        chk(tag, "is_err", 64'(timeout_err), 64'(v.err));
        chk(tag, "cycles", 64'(n), 64'(v.cycles));
        chk(tag, "busy_hold", 64'(blo), 64'd0);
        chk(tag, "start_any", 64'(any), v.err ? 64'(v.tlim) : 64'(RUNS * (1 + m)));
        chk(tag, "result", result, er);
        if (!v.err) begin
            chk(tag, "bdone", 64'(batch_done), 64'd1);
            chk(tag, "rvalid", 64'(result_valid), 64'd1);
            chk(tag, "runs", 64'(run_count), 64'(RUNS));
            chk(tag, "start_one", 64'(one), 64'(RUNS * df));
        end else begin
            chk(tag, "err_start", 64'(net_start), 64'd0);
            chk(tag, "err_rvalid", 64'(result_valid), 64'd0);
            chk(tag, "err_bdone", 64'(batch_done), 64'd0);
            chk(tag, "err_runs", 64'(run_count), 64'd0);
        end
        @(posedge clk); #1;
        chk(tag, "post_bdone", 64'(batch_done), 64'd0);
        chk(tag, "post_busy", 64'(busy), 64'd0);
        chk(tag, "post_rvalid", 64'(result_valid), 64'(!v.err));
        chk(tag, "post_terr", 64'(timeout_err), 64'(v.err));
        prev = er;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t va;
        int d0, d1, k;
        logic [15:0] tl;
        bit g;
        // Rows: d0 d1 b0 s0 b1 s1 tlim glitch go_busy | err cycles res_last res_sum keep
        tbl.push_back('{5, 5, 32'h10, 32'h0, 32'h20, 32'h0, 16'd0, 1'b0, 1'b0,
                        1'b0, 25, 64'h00000020_00000010, 64'h00000060_00000030, 2'b00});
        tbl.push_back('{3, 7, 32'hA, 32'h0, 32'hB, 32'h0, 16'd0, 1'b0, 1'b1,
                        1'b0, 31, 64'h0000000B_0000000A, 64'h00000021_0000001E, 2'b00});
        tbl.push_back('{1000, 1000, 32'h1, 32'h0, 32'h2, 32'h0, 16'd4, 1'b0, 1'b0,
                        1'b1, 6, 64'h0, 64'h0, 2'b11});
        tbl.push_back('{2, 4, 32'h1, 32'h1, 32'h100, 32'h10, 16'd5, 1'b0, 1'b0,
                        1'b0, 22, 64'h00000120_00000003, 64'h00000330_00000006, 2'b00});
        tbl.push_back('{2, 4, 32'h77, 32'h0, 32'h88, 32'h0, 16'd4, 1'b0, 1'b0,
                        1'b1, 6, 64'h00000000_00000077, 64'h00000000_00000077, 2'b10});
        tbl.push_back('{1, 7, 32'h5, 32'h1, 32'h7, 32'h0, 16'd0, 1'b1, 1'b0,
                        1'b0, 31, 64'h00000007_00000007, 64'h00000015_00000012, 2'b00});
        for (int i = 0; i < 8; i++) begin
            d0 = $urandom_range(1, 10);
            d1 = $urandom_range(1, 10);
            tl = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(2, 14));
            g  = (tl == 16'd0 && d1 >= d0 + 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            tbl.push_back(mk(d0, d1, $urandom(), $urandom(), $urandom(), $urandom(), tl, g,
                             1'($urandom_range(0, 1))));
        end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst", "outs", {net_start, busy, batch_done, timeout_err, run_count, result_valid}, 64'd0);
        chk("rst", "result", result, 64'd0);
        @(negedge clk); reset = 1'b1;

        foreach (tbl[i]) run_scenario(tbl[i], $sformatf("vec%0d", i));

        // Abort in WAIT of run 2, then abort beats go, then a full batch.
        va = mk(2, 3, 32'h31, 32'h2, 32'h41, 32'h3, 16'd0, 1'b0, 1'b0);
        set_emu(va); timeout_lim = '0;
        pulse_go();
        k = 0;
        while (!(run_count == CW'(1) && net_start != 2'b00) && k < 200) begin @(posedge clk); #1; k++; end
        chk("abort", "reach", 64'(k < 200), 64'd1);
        abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        chk("abort", "busy", 64'(busy), 64'd0);
        chk("abort", "start", 64'(net_start), 64'd0);
        chk("abort", "runs", 64'(run_count), 64'd1);
        chk("abort", "bdone", 64'(batch_done), 64'd0);
        @(posedge clk); #1;
        chk("abort", "bdone2", 64'(batch_done), 64'd0);
        go = 1'b1; abort = 1'b1; @(posedge clk); #1; go = 1'b0; abort = 1'b0;
        chk("abort_go", "busy", 64'(busy), 64'd0);
        chk("abort_go", "runs", 64'(run_count), 64'd1);
        run_scenario(va, "after_abort");

        // Done already high before launch plus done in IDLE: nothing captured.
        emu_en = 1'b0;
        net_done = 2'b11; net_out = {32'hBAD1_0001, 32'hBAD0_0000};
        repeat (2) @(posedge clk);
        #1;
        chk("idle_done", "result", result, prev);
        chk("idle_done", "rvalid", 64'(result_valid), 64'd1);
        timeout_lim = 16'd3;
        pulse_go();
        k = 1;
        while (!timeout_err && k < 100) begin @(posedge clk); #1; k++; end
        chk("high_at_launch", "cycles", 64'(k), 64'd5);
`ifdef NETWORK_BATCH_ACCUM_EN
        chk("high_at_launch", "result", result, 64'd0);
        prev = '0;
`else
        chk("high_at_launch", "result", result, prev);
`endif
        @(posedge clk); #1;
        net_done = 2'b00; emu_en = 1'b1;
        repeat (2) @(posedge clk);

        // Asynchronous reset in WAIT of run 2.
        va = mk(6, 6, 32'h55, 32'h1, 32'h66, 32'h1, 16'd0, 1'b0, 1'b0);
        set_emu(va); timeout_lim = '0;
        pulse_go();
        k = 0;
        while (!(run_count == CW'(1) && net_start != 2'b00) && k < 200) begin @(posedge clk); #1; k++; end
        repeat (2) @(posedge clk);
        #1;
        chk("midrst", "pre_busy", 64'(busy), 64'd1);
        #1; reset = 1'b0; #1;
        chk("midrst", "outs", {net_start, busy, batch_done, timeout_err, run_count, result_valid}, 64'd0);
        chk("midrst", "result", result, 64'd0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
